rice_partition_decoder: RTL and testbench

- Decompression-side counterpart of the Stage 4 compress path: reads one Rice-coded residual partition from a 16-bit-word RAM and emits signed 16-bit residuals, one per valid strobe.
- Bitstream format matches the encoder's RiceWriter output:
  - 4-bit Rice parameter k first.
  - Then per sample: q zeros, a terminating 1, then k LSBs.
  - Bits are MSB-first within each word; words are read at ascending addresses.
- Feeds the downstream LPC reconstruction stage.

---
 rtl/rice_pkg.sv | 30 +++
 rtl/rice_bit_fifo.sv | 93 +++++++++
 rtl/rice_partition_decoder.sv | 179 +++++++++++++++++
 tb/tb_rice_partition_decoder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rice_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rice_pkg
//  Description : Shared definitions for the Rice residual partition decoder:
//                parameter width, escape code, decoder state encoding and the
//                zig-zag (folded unsigned -> signed) mapping.
//  Revision    : 1.0 - initial release
// ============================================================================
package rice_pkg;

    localparam int RICE_PARAM_W = 4;
    localparam logic [RICE_PARAM_W-1:0] RICE_ESCAPE = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PARAM = 3'd1,
        ST_UNARY = 3'd2,
        ST_LSB   = 3'd3,
        ST_EMIT  = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERROR = 3'd6
    } rice_state_e;

    // Even u maps to u/2, odd u maps to -((u>>1)+1), i.e. the bitwise inverse.
    function automatic logic [15:0] zigzag_decode(input logic [15:0] u);
        return u[0] ? ~(u >> 1) : (u >> 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rice_bit_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rice_bit_fifo
//  Description : 32-bit left-aligned bit buffer fed from a word RAM. Bits are
//                consumed MSB-first through a peek/pop(n<=15) interface and
//                refilled one word at a time from ascending addresses.
//  Ports       : iClock/iReset_n  clock, async active-low reset
//                iEnable          clock enable (all state holds when low)
//                iClear/iBaseAddress  empty buffer, drop fetch, load address
//                iActive          refills allowed / returned data accepted
//                iPopEn/iPopN     consume iPopN bits this cycle
//                oPeek/oFill      top DATA_W bits and number of valid bits
//                oRamReadEnable/oRamAddress/iRamData  RAM read port
//  Revision    : 1.0 - initial release
// ============================================================================
module rice_bit_fifo #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic              iClock,
    input  logic              iReset_n,
    input  logic              iEnable,
    input  logic              iClear,
    input  logic [ADDR_W-1:0] iBaseAddress,
    input  logic              iActive,
    input  logic              iPopEn,
    input  logic [3:0]        iPopN,
    output logic [DATA_W-1:0] oPeek,
    output logic [5:0]        oFill,
    output logic              oRamReadEnable,
    output logic [ADDR_W-1:0] oRamAddress,
    input  logic [DATA_W-1:0] iRamData
);

    logic [2*DATA_W-1:0] buf_q, buf_d, buf_pop;
    logic [5:0]          fill_q, fill_d, fill_pop;
    logic                pend_q, pend_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                fetch;

    assign fetch          = iEnable && iActive && !pend_q && (fill_q <= 6'd16);
    assign oRamReadEnable = fetch;
    assign oRamAddress    = addr_q;
    assign oPeek          = buf_q[2*DATA_W-1 -: DATA_W];
    assign oFill          = fill_q;

    always_comb begin
        buf_pop  = iPopEn ? (buf_q << iPopN) : buf_q;
        fill_pop = iPopEn ? (fill_q - {2'b00, iPopN}) : fill_q;
        buf_d    = buf_q;
        fill_d   = fill_q;
        pend_d   = pend_q;
        addr_d   = addr_q;
        if (iClear) begin
            buf_d  = '0;
            fill_d = '0;
            pend_d = 1'b0;
            addr_d = iBaseAddress;
        end else if (iEnable) begin
            buf_d  = buf_pop;
            fill_d = fill_pop;
            if (pend_q) begin
                pend_d = 1'b0;
                // The word lands directly below the bits left after this
                // cycle's pop; once the decoder stops, late data is dropped.
                if (iActive) begin
                    buf_d  = buf_pop | ({iRamData, {DATA_W{1'b0}}} >> fill_pop);
                    fill_d = fill_pop + 6'd16;
                end
            end
            if (fetch) begin
                pend_d = 1'b1;
                addr_d = addr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            buf_q  <= '0;
            fill_q <= '0;
            pend_q <= 1'b0;
            addr_q <= '0;
        end else begin
            buf_q  <= buf_d;
            fill_q <= fill_d;
            pend_q <= pend_d;
            addr_q <= addr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rice_partition_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : rice_partition_decoder
//  Description : Decodes one Rice-coded residual partition (4-bit parameter k,
//                then per sample q zeros, a 1 and k LSBs) into signed
//                residuals, one per oValid pulse.
//  Ports       : iClock/iReset_n/iEnable  clock, async reset, clock enable
//                iStart/iBaseAddress/iNSamples  partition launch
//                oRamReadEnable/oRamAddress/iRamData  RAM read port
//                oValid/oResidual  decoded residual stream
//                oRiceParam/oBusy/oDone/oError  status
//  Revision    : 1.0 - initial release
// ============================================================================
module rice_partition_decoder
    import rice_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 16,
    parameter int PARTITION_SIZE = 4096
) (
    input  logic              iClock,
    input  logic              iReset_n,
    input  logic              iEnable,
    input  logic              iStart,
    input  logic [ADDR_W-1:0] iBaseAddress,
    input  logic [15:0]       iNSamples,
    output logic              oRamReadEnable,
    output logic [ADDR_W-1:0] oRamAddress,
    input  logic [DATA_W-1:0] iRamData,
    output logic              oValid,
    output logic [DATA_W-1:0] oResidual,
    output logic [RICE_PARAM_W-1:0] oRiceParam,
    output logic              oBusy,
    output logic              oDone,
    output logic              oError
);

    rice_state_e              state_q, state_d;
    logic [RICE_PARAM_W-1:0]  k_q, k_d;
    logic [16:0]              q_q, q_d;
    logic [DATA_W-1:0]        lsb_q, lsb_d;
    logic [15:0]              cnt_q, cnt_d;
    logic [15:0]              nsamp_q, nsamp_d;
    logic [DATA_W-1:0]        res_q, res_d;
    logic                     valid_q, valid_d;
    logic                     done_q, done_d;

    logic [DATA_W-1:0]        peek;
    logic [5:0]               fill;
    logic                     pop_en, clear, active, start_ok;
    logic [3:0]               pop_n;
    logic [16:0]              q_inc;
    logic [DATA_W-1:0]        u;

    assign active   = (state_q == ST_PARAM) || (state_q == ST_UNARY) ||
                      (state_q == ST_LSB)   || (state_q == ST_EMIT);
    assign start_ok = iEnable && iStart &&
                      ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERROR));
    assign q_inc    = q_q + 17'd1;
    assign u        = (q_q[DATA_W-1:0] << k_q) | lsb_q;

    rice_bit_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fifo (
        .iClock         (iClock),
        .iReset_n       (iReset_n),
        .iEnable        (iEnable),
        .iClear         (clear),
        .iBaseAddress   (iBaseAddress),
        .iActive        (active),
        .iPopEn         (pop_en),
        .iPopN          (pop_n),
        .oPeek          (peek),
        .oFill          (fill),
        .oRamReadEnable (oRamReadEnable),
        .oRamAddress    (oRamAddress),
        .iRamData       (iRamData)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        q_d     = q_q;
        lsb_d   = lsb_q;
        cnt_d   = cnt_q;
        nsamp_d = nsamp_q;
        res_d   = res_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        pop_en  = 1'b0;
        pop_n   = 4'd0;
        clear   = 1'b0;
        if (iEnable) begin
            case (state_q)
                ST_PARAM: if (fill >= 6'd4) begin
                    pop_en = 1'b1;
                    pop_n  = 4'd4;
                    k_d    = peek[DATA_W-1 -: RICE_PARAM_W];
                    if (peek[DATA_W-1 -: RICE_PARAM_W] == RICE_ESCAPE) state_d = ST_ERROR;
                    else if (nsamp_q == 16'd0)                           state_d = ST_DONE;
                    else                                                 state_d = ST_UNARY;
                end
                ST_UNARY: if (fill >= 6'd1) begin
                    pop_en = 1'b1;
                    pop_n  = 4'd1;
                    if (peek[DATA_W-1]) begin
                        state_d = ST_LSB;
                    end else begin
                        q_d = q_inc;
                        // A quotient whose shifted value no longer fits in a
                        // residual word can only come from a corrupt stream.
                        if (q_inc > (17'h0FFFF >> k_q)) state_d = ST_ERROR;
                    end
                end
                ST_LSB: begin
                    if (k_q == '0) begin
                        lsb_d   = '0;
                        state_d = ST_EMIT;
                    end else if (fill >= {2'b00, k_q}) begin
                        pop_en  = 1'b1;
                        pop_n   = k_q;
                        lsb_d   = peek >> (5'(DATA_W) - {1'b0, k_q});
                        state_d = ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    valid_d = 1'b1;
                    res_d   = zigzag_decode(u);
                    q_d     = '0;
                    cnt_d   = cnt_q + 16'd1;
                    state_d = (cnt_q + 16'd1 == nsamp_q) ? ST_DONE : ST_UNARY;
                end
                ST_DONE: begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
                default: ;
            endcase
            if (start_ok) begin
                clear   = 1'b1;
                nsamp_d = (iNSamples > 16'(PARTITION_SIZE)) ? 16'(PARTITION_SIZE) : iNSamples;
                cnt_d   = '0;
                q_d     = '0;
                state_d = ST_PARAM;
            end
        end
    end

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            q_q     <= '0;
            lsb_q   <= '0;
            cnt_q   <= '0;
            nsamp_q <= '0;
            res_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            q_q     <= q_d;
            lsb_q   <= lsb_d;
            cnt_q   <= cnt_d;
            nsamp_q <= nsamp_d;
            res_q   <= res_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign oValid     = valid_q;
    assign oDone      = done_q;
    assign oResidual  = res_q;
    assign oRiceParam = k_q;
    assign oBusy      = active;
    assign oError     = (state_q == ST_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_rice_partition_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rice_partition_decoder
//  Description : Self-checking bench for rice_partition_decoder. A bit-serial
//                reference decoder reads the same RAM image and predicts k,
//                the residual list, the error outcome and the bit count.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rice_partition_decoder;

    logic        iClock = 1'b0;
    logic        iReset_n;
    logic        iEnable;
    logic        iStart;
    logic [15:0] iBaseAddress;
    logic [15:0] iNSamples;
    logic        oRamReadEnable;
    logic [15:0] oRamAddress;
    logic [15:0] iRamData = '0;
    logic        oValid;
    logic [15:0] oResidual;
    logic [3:0]  oRiceParam;
    logic        oBusy;
    logic        oDone;
    logic        oError;

    rice_partition_decoder dut (
        .iClock(iClock), .iReset_n(iReset_n), .iEnable(iEnable), .iStart(iStart),
        .iBaseAddress(iBaseAddress), .iNSamples(iNSamples),
        .oRamReadEnable(oRamReadEnable), .oRamAddress(oRamAddress), .iRamData(iRamData),
        .oValid(oValid), .oResidual(oResidual), .oRiceParam(oRiceParam),
        .oBusy(oBusy), .oDone(oDone), .oError(oError)
    );

    always #5 iClock = ~iClock;

    logic [15:0] mem [256];

    // RAM: registered read, output held while iEnable is low.
    always @(posedge iClock)
        if (iEnable && oRamReadEnable) iRamData <= mem[oRamAddress[7:0]];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] exp_res[$];
    logic [15:0] got_res[$];
    int          exp_k, exp_bits;
    bit          exp_err;
    int          m_base;

    function automatic int getbit(input int pos);
        logic [15:0] w;
        w = mem[(m_base + pos / 16) & 255];
        return int'(w[15 - (pos % 16)]);
    endfunction

    task automatic model(input int base, input int n);
        int pos, q, lsb, u;
        m_base = base;
        exp_res.delete();
        exp_err = 0;
        pos = 0;
        exp_k = 0;
        for (int j = 0; j < 4; j++) exp_k = exp_k * 2 + getbit(pos++);
        if (exp_k == 15) exp_err = 1;
        for (int s = 0; s < n && !exp_err; s++) begin
            q = 0;
            while (getbit(pos++) == 0) begin
                q++;
                if (q > (65535 >> exp_k)) begin exp_err = 1; break; end
            end
            if (exp_err) break;
            lsb = 0;
            for (int j = 0; j < exp_k; j++) lsb = lsb * 2 + getbit(pos++);
            u = ((q << exp_k) | lsb) & 16'hFFFF;
            exp_res.push_back((u % 2 == 1) ? 16'(-(u / 2) - 1) : 16'(u / 2));
        end
        exp_bits = pos;
    endtask

    function automatic logic [31:0] gotv(input int i);
        return (got_res.size() > i) ? {16'h0, got_res[i]} : 32'hDEAD_BEEF;
    endfunction

    // ---------------- one partition ----------------
    task automatic run_case(input string tag, input int base, input int n,
                            input bit rnd_en, input int reset_after);
        int  nreads = 0, addr_bad = 0, idle_reads = 0, overlap = 0, extra = 0;
        bit  saw_done = 0, saw_err = 0;
        int  lo, hi;
        model(base, n);
        got_res.delete();
        @(posedge iClock); #1;
        iBaseAddress = 16'(base);
        iNSamples    = 16'(n);
        iStart       = 1'b1;
        iEnable      = 1'b1;
        @(posedge iClock); #1;
        iStart  = 1'b0;
        iEnable = rnd_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        for (int cyc = 0; cyc < 5000 && !(saw_done || saw_err); cyc++) begin
            @(negedge iClock);
            if (oRamReadEnable) begin
                if (oRamAddress !== 16'(base + nreads)) addr_bad++;
                if (!oBusy) idle_reads++;
                nreads++;
            end
            if (oValid) got_res.push_back(oResidual);
            if (oValid && oDone) overlap++;
            if (oDone) saw_done = 1;
            if (oError) saw_err = 1;
            if (reset_after > 0 && got_res.size() == reset_after) begin
                #2 iReset_n = 1'b0;
                #1;
                check({tag, "_rst_ctl"}, {oValid, oDone, oBusy, oError, oRamReadEnable, oRiceParam}, 0);
                check({tag, "_rst_res"}, oResidual, 0);
                check({tag, "_rst_addr"}, oRamAddress, 0);
                @(posedge iClock); #1;
                iReset_n = 1'b1;
                iEnable  = 1'b1;
                return;
            end
            @(posedge iClock); #1;
            iEnable = rnd_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        check({tag, "_finished"}, saw_done || saw_err, 1);
        iEnable = 1'b1;
        for (int t = 0; t < 8; t++) begin
            @(negedge iClock);
            if (oRamReadEnable) idle_reads++;
            if (oValid || oDone) extra++;
        end
        check({tag, "_done"}, saw_done, !exp_err);
        check({tag, "_err"}, saw_err, exp_err);
        check({tag, "_err_hold"}, oError, exp_err);
        check({tag, "_k"}, oRiceParam, exp_k);
        check({tag, "_count"}, got_res.size(), exp_res.size());
        for (int i = 0; i < exp_res.size(); i++)
            check({tag, "_res"}, gotv(i), exp_res[i]);
        lo = (exp_bits + 15) / 16;
        hi = (exp_bits + 16) / 16 + 1;
        check({tag, "_reads_lo"}, nreads >= lo, 1);
        check({tag, "_reads_hi"}, nreads <= hi, 1);
        check({tag, "_addr_seq"}, addr_bad, 0);
        check({tag, "_idle_reads"}, idle_reads, 0);
        check({tag, "_valid_done_overlap"}, overlap, 0);
        check({tag, "_tail_pulses"}, extra, 0);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    int bitpos;
    task automatic put_bits(input int base, input int v, input int nb);
        for (int j = nb - 1; j >= 0; j--) begin
            mem[(base + bitpos / 16) & 255][15 - (bitpos % 16)] = 1'((v >> j) & 1);
            bitpos++;
        end
    endtask

    task automatic build_random(input int base, input int n, input int k);
        int q, qmax;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        bitpos = 0;
        put_bits(base, k, 4);
        qmax = (65535 >> k) < 6 ? (65535 >> k) : 6;
        for (int s = 0; s < n; s++) begin
            q = $urandom_range(0, qmax);
            put_bits(base, 0, q);
            put_bits(base, 1, 1);
            if (k > 0) put_bits(base, int'($urandom_range(0, (1 << k) - 1)), k);
        end
    endtask

    initial begin
        iReset_n = 1'b0; iEnable = 1'b0; iStart = 1'b0;
        iBaseAddress = '0; iNSamples = '0;
        #12;
        check("reset_ctl", {oValid, oDone, oBusy, oError, oRamReadEnable, oRiceParam}, 0);
        check("reset_res", oResidual, 0);
        check("reset_addr", oRamAddress, 0);
        @(posedge iClock); #1;
        iReset_n = 1'b1;

        clear_mem(); mem[0] = 16'h2970;
        run_case("basic", 0, 3, 0, 0);
        check("basic_r0", gotv(0), 16'h0000);
        check("basic_r1", gotv(1), 16'hFFFF);
        check("basic_r2", gotv(2), 16'h0001);

        clear_mem(); mem[0] = 16'h0020;
        run_case("k0", 0, 1, 0, 0);
        check("k0_r0", gotv(0), 16'h0003);

        clear_mem(); mem[0] = 16'h2FFF; mem[1] = 16'hFFF0;
        run_case("straddle", 0, 7, 0, 0);
        for (int i = 0; i < 7; i++) check("straddle_val", gotv(i), 16'hFFFE);

        clear_mem(); mem[0] = 16'hE000;
        run_case("qovf", 0, 5, 0, 0);
        check("qovf_err", oError, 1);

        clear_mem(); mem[0] = 16'hF000;
        run_case("escape", 0, 4, 0, 0);
        check("escape_err", oError, 1);

        clear_mem(); mem[0] = 16'h3000;
        run_case("nzero", 0, 0, 0, 0);
        check("nzero_k", oRiceParam, 3);

        clear_mem(); mem[0] = 16'h2970;
        run_case("midreset", 0, 3, 0, 1);
        run_case("after_reset", 0, 3, 0, 0);
        check("after_reset_r1", gotv(1), 16'hFFFF);
        run_case("stall", 0, 3, 1, 0);
        check("stall_r1", gotv(1), 16'hFFFF);
        check("stall_r2", gotv(2), 16'h0001);

        for (int r = 0; r < 10; r++) begin
            int base, n, k;
            base = $urandom_range(0, 200);
            n    = $urandom_range(1, 24);
            k    = $urandom_range(0, 14);
            build_random(base, n, k);
            run_case("rand", base, n, r[0], 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
